// File: rtl/register_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : register_arbiter (with helper cell register_bit)
// Description : Shares one 16-bit storage register between two requesters.
//               Requests are arbitrated round-robin and each granted access
//               runs as a fixed IDLE -> GRANT -> DONE transaction. The block
//               owns the register's load/in pins and supplies its reset.
// Ports       : clk            rising-edge clock
//               rst_n          synchronous active-low reset
//               req[1:0]       per-requester request
//               we[1:0]        per-requester write enable (used in GRANT)
//               wdata0/wdata1  per-requester write data (used in GRANT)
//               gnt[1:0]       one-hot grant, high in GRANT and DONE
//               done[1:0]      one-cycle completion pulse in DONE
//               busy           high whenever the FSM is not IDLE
//               out[15:0]      current register contents (signed)
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// register_bit : single storage cell with load enable and no reset.
// ----------------------------------------------------------------------------
module register_bit (
    input  logic clk,
    input  logic load,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

module register_arbiter (
    input  logic               clk,
    input  logic               rst_n,
    input  logic        [1:0]  req,
    input  logic        [1:0]  we,
    input  logic        [15:0] wdata0,
    input  logic        [15:0] wdata1,
    output logic        [1:0]  gnt,
    output logic        [1:0]  done,
    output logic               busy,
    output logic signed [15:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_win;          // requester owning the current transaction
    logic        w_win_next;
    logic        r_last;         // most recent winner, loses the next tie
    logic        w_reg_load;
    logic [15:0] w_reg_in;
    logic [15:0] w_reg_q;

    // ------------------------------------------------------------------------
    // State, winner and pointer registers. gnt/done/busy are registered from
    // the next-state decode so they change only on clock edges.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_win   <= 1'b0;
            r_last  <= 1'b1;
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_win   <= w_win_next;
            if (r_state == DONE) begin
                r_last <= r_win;
            end
            gnt  <= (w_state_next == GRANT || w_state_next == DONE)
                    ? (w_win_next ? 2'b10 : 2'b01) : 2'b00;
            done <= (w_state_next == DONE)
                    ? (w_win_next ? 2'b10 : 2'b01) : 2'b00;
            busy <= (w_state_next != IDLE);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, arbitration and register-port decode.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_win_next   = r_win;
        w_reg_load   = 1'b0;
        w_reg_in     = r_win ? wdata1 : wdata0;

        case (r_state)
            IDLE: begin
                case (req)
                    2'b01: begin
                        w_win_next   = 1'b0;
                        w_state_next = GRANT;
                    end
                    2'b10: begin
                        w_win_next   = 1'b1;
                        w_state_next = GRANT;
                    end
                    2'b11: begin
                        // Tie: whoever did not win last time goes first.
                        w_win_next   = ~r_last;
                        w_state_next = GRANT;
                    end
                    default: begin
                        w_state_next = IDLE;
                    end
                endcase
            end
            GRANT: begin
                // With we low this is a read slot: the register holds.
                w_reg_load   = r_win ? we[1] : we[0];
                w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // The storage cells have no reset; clear them through the load path.
        if (!rst_n) begin
            w_reg_load = 1'b1;
            w_reg_in   = 16'h0000;
        end
    end

    // ------------------------------------------------------------------------
    // Shared 16-bit register built from individual cells.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 16; i++) begin : g_bits
            register_bit u_bit (
                .clk  (clk),
                .load (w_reg_load),
                .d    (w_reg_in[i]),
                .q    (w_reg_q[i])
            );
        end
    endgenerate

    assign out = w_reg_q;

endmodule
`default_nettype wire
